// File: rtl/sspim_seq_if.sv
// Register bus between the SPI word sequencer (master) and the SPI master's
// register file (slave). rdata is only meaningful in the cycle ack is high.
interface sspim_seq_if;
    logic        cs;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;

    modport master (output cs, wr, addr, wdata, be, input rdata, ack);
    modport slave  (input cs, wr, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/sspim_seq.sv
// Streams 32-bit words through an SPI master's register bus: write TX data,
// kick op_req, poll until hardware clears it, optionally return RX data.
module sspim_seq #(
    parameter logic [7:0]  CTRL_ADDR  = 8'h00,
    parameter logic [7:0]  WDATA_ADDR = 8'h08,
    parameter logic [7:0]  RDATA_ADDR = 8'h0C,
    parameter int unsigned OPREQ_BIT  = 31,
    parameter logic [15:0] POLL_TMO   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [31:0] cmd_ctrl,
    input  logic [7:0]  cmd_words,
    input  logic        cmd_rx_en,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    input  logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    sspim_seq_if.master m_reg
);

    localparam logic [31:0] OPREQ_MASK = 32'd1 << OPREQ_BIT;

    typedef enum logic [3:0] {
        IDLE, TXW, WRD, WRC, POL, RDD, RXP, NXT, FIN
    } state_e;

    typedef struct packed {
        logic [31:0] ctrl;
        logic        rx_en;
    } cmd_t;

    state_e      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [7:0]  words_q, words_d;
    logic [15:0] poll_q, poll_d;
    logic [15:0] poll_inc;
    logic [31:0] txd_q, txd_d;
    logic [31:0] rxd_q, rxd_d;
    logic        err_q, err_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    assign poll_inc = poll_q + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            words_q <= '0;
            poll_q  <= '0;
            txd_q   <= '0;
            rxd_q   <= '0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            words_q <= words_d;
            poll_q  <= poll_d;
            txd_q   <= txd_d;
            rxd_q   <= rxd_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Each bus state spends its first cycle with cs low and raises cs on the
    // next edge; that first cycle is the mandatory idle gap between accesses.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        words_d = words_q;
        poll_d  = poll_q;
        txd_d   = txd_q;
        rxd_d   = rxd_q;
        err_d   = err_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    cmd_d.ctrl  = cmd_ctrl | OPREQ_MASK;
                    cmd_d.rx_en = cmd_rx_en;
                    words_d     = cmd_words;
                    err_d       = 1'b0;
                    state_d     = (cmd_words == 8'd0) ? FIN : TXW;
                end
            end
            TXW: begin
                if (tx_valid) begin
                    txd_d   = tx_data;
                    state_d = WRD;
                end
            end
            WRD: begin
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = WDATA_ADDR;
                    wdata_d = txd_q;
                end else if (m_reg.ack) begin
                    cs_d    = 1'b0;
                    state_d = WRC;
                end
            end
            WRC: begin
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = CTRL_ADDR;
                    wdata_d = cmd_q.ctrl;
                end else if (m_reg.ack) begin
                    cs_d    = 1'b0;
                    poll_d  = '0;
                    state_d = POL;
                end
            end
            POL: begin
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = CTRL_ADDR;
                    wdata_d = '0;
                end else if (m_reg.ack) begin
                    cs_d = 1'b0;
                    if (!m_reg.rdata[OPREQ_BIT]) begin
                        state_d = cmd_q.rx_en ? RDD : NXT;
                    end else begin
                        // Staying in POL re-issues the read after the idle cycle.
                        poll_d = poll_inc;
                        if (poll_inc == POLL_TMO) begin
                            err_d   = 1'b1;
                            state_d = FIN;
                        end
                    end
                end
            end
            RDD: begin
                if (!cs_q) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = RDATA_ADDR;
                    wdata_d = '0;
                end else if (m_reg.ack) begin
                    cs_d    = 1'b0;
                    rxd_d   = m_reg.rdata;
                    state_d = RXP;
                end
            end
            RXP: begin
                if (rx_ready) state_d = NXT;
            end
            NXT: begin
                words_d = words_q - 8'd1;
                state_d = (words_q == 8'd1) ? FIN : TXW;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_ready = (state_q == TXW) && tx_valid;
    assign rx_valid = (state_q == RXP);
    assign rx_data  = rxd_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign err      = err_q;

    assign m_reg.cs    = cs_q;
    assign m_reg.wr    = wr_q;
    assign m_reg.addr  = addr_q;
    assign m_reg.wdata = wdata_q;
    assign m_reg.be    = {4{cs_q}};

endmodule

// File: tb/tb_sspim_seq.sv
// Directed bench for sspim_seq: register-file responder with programmable ack
// latency and op_req clearing, TX source, RX sink and bus protocol monitor.
module tb_sspim_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [31:0] cmd_ctrl = '0;
    logic [7:0]  cmd_words = '0;
    logic        cmd_rx_en = 1'b0;
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready = 1'b1;
    logic        busy, done, err;

    always #5 clk = ~clk;

    sspim_seq_if m_reg ();

    sspim_seq #(.POLL_TMO(16'd3)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_ctrl(cmd_ctrl), .cmd_words(cmd_words), .cmd_rx_en(cmd_rx_en),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err),
        .m_reg(m_reg)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        log_q[$];
    logic [31:0] tx_words[$], tx_cons[$], rx_vals[$], rx_got[$];
    int tx_idx, tx_gap_max, lat, clear_poll, poll_n, rx_idx;
    int stall_word, stall_left, stall_seen;
    int viol, busy_cyc, cs_cyc, done_cnt;
    int n_chk = 0, n_err = 0;
    logic tx_take = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic acc_t acc(input logic w, input logic [7:0] a, input logic [31:0] d);
        acc_t r;
        r.wr = w; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic chk_log(input string tag, input acc_t e[$]);
        chk({tag, "_nacc"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk($sformatf("%s_acc%0d", tag, i), {log_q[i].wr, log_q[i].addr, log_q[i].wdata},
                {e[i].wr, e[i].addr, e[i].wdata});
    endtask

    // Register-file responder, protocol monitor and RX sink.
    initial begin
        logic        ack_seen, prev_cs;
        logic [40:0] prev_bus;
        int          wcnt, cur_lat;
        acc_t        a;
        m_reg.ack = 1'b0; m_reg.rdata = '0;
        prev_cs = 1'b0; prev_bus = '0; wcnt = 0; cur_lat = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_reg.ack = 1'b0; wcnt = 0; prev_cs = 1'b0;
            end else begin
                ack_seen = m_reg.ack;
                if (m_reg.cs && m_reg.be !== 4'hF) viol++;
                if (prev_cs && m_reg.cs && !ack_seen &&
                    {m_reg.wr, m_reg.addr, m_reg.wdata} !== prev_bus) viol++;
                if (ack_seen && m_reg.cs) viol++;
                if (prev_cs && !m_reg.cs && !ack_seen) viol++;
                if (rx_valid && (tx_ready || m_reg.cs)) viol++;
                if (busy) busy_cyc++;
                if (m_reg.cs) cs_cyc++;
                if (done) done_cnt++;
                prev_cs  = m_reg.cs;
                prev_bus = {m_reg.wr, m_reg.addr, m_reg.wdata};

                if (m_reg.ack) begin
                    m_reg.ack = 1'b0;
                end else if (m_reg.cs) begin
                    if (wcnt == 0) cur_lat = (lat < 0) ? int'($urandom_range(0, 6)) : lat;
                    if (wcnt >= cur_lat) begin
                        a = acc(m_reg.wr, m_reg.addr, m_reg.wr ? m_reg.wdata : 32'h0);
                        log_q.push_back(a);
                        m_reg.rdata = 32'h0;
                        if (m_reg.wr && m_reg.addr == 8'h00) poll_n = 0;
                        if (!m_reg.wr && m_reg.addr == 8'h00) begin
                            poll_n++;
                            m_reg.rdata = (clear_poll == 0 || poll_n < clear_poll) ?
                                          32'h8000_0000 : 32'h7FFF_FFFF;
                        end else if (!m_reg.wr && m_reg.addr == 8'h0C) begin
                            m_reg.rdata = (rx_idx < rx_vals.size()) ? rx_vals[rx_idx] : 32'hDEAD_DEAD;
                            rx_idx++;
                        end
                        m_reg.ack = 1'b1;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end

                if (rx_valid) begin
                    if (rx_got.size() == stall_word - 1 && stall_left > 0) begin
                        rx_ready = 1'b0; stall_left--; stall_seen++;
                    end else begin
                        rx_ready = 1'b1; rx_got.push_back(rx_data);
                    end
                end else begin
                    rx_ready = 1'b1;
                end
            end
        end
    end

    // TX source: tx_valid changes 2 time units after negedge so tx_ready is
    // settled at the following negedge, where a pending handshake is seen.
    initial begin
        logic drop;
        int   gap;
        gap = 0;
        forever begin
            @(negedge clk);
            drop = tx_take; tx_take = 1'b0;
            if (!drop && tx_valid && tx_ready) begin
                tx_take = 1'b1;
                tx_cons.push_back(tx_data);
            end
            #2;
            if (drop) begin
                tx_valid = 1'b0;
                tx_idx++;
                gap = (tx_gap_max > 0) ? int'($urandom_range(0, tx_gap_max)) : 0;
            end
            if (!tx_valid && !tx_take && tx_idx < tx_words.size()) begin
                if (gap > 0) gap--;
                else begin
                    tx_valid = 1'b1;
                    tx_data  = tx_words[tx_idx];
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int cp, input int l, input int gmax);
        clear_poll = cp; lat = l; tx_gap_max = gmax;
        log_q.delete(); tx_words.delete(); tx_cons.delete(); rx_vals.delete(); rx_got.delete();
        tx_idx = 0; tx_valid = 1'b0; rx_idx = 0; poll_n = 0;
        stall_word = 0; stall_left = 0; stall_seen = 0;
        viol = 0; busy_cyc = 0; cs_cyc = 0; done_cnt = 0;
    endtask

    task automatic start(input logic [31:0] c, input logic [7:0] w, input logic rxe);
        tick;
        cmd_start = 1'b1; cmd_ctrl = c; cmd_words = w; cmd_rx_en = rxe;
        tick;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim, output int cyc);
        cyc = 0;
        while (!done && cyc < lim) begin
            tick;
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    initial begin
        int   c, k;
        acc_t e[$];
        logic [31:0] wd[$];

        // reset state
        load(1, 0, 0);
        tick; tick;
        chk("rst_ctl", {busy, done, err, tx_ready, rx_valid, m_reg.cs, m_reg.wr, m_reg.be}, '0);
        chk("rst_addr", m_reg.addr, 8'h00);
        chk("rst_wdata", m_reg.wdata, 32'h0);
        chk("rst_rxdata", rx_data, 32'h0);
        reset_n = 1'b1;
        tick;

        // single word, ack after 1 cycle, op_req clears on third poll
        load(3, 1, 0);
        tx_words.push_back(32'hA5A5_1234);
        start(32'h0000_1003, 8'd1, 1'b0);
        wait_done("t1", 500, c);
        tick;
        e.delete();
        e.push_back(acc(1'b1, 8'h08, 32'hA5A5_1234));
        e.push_back(acc(1'b1, 8'h00, 32'h8000_1003));
        for (int i = 0; i < 3; i++) e.push_back(acc(1'b0, 8'h00, 32'h0));
        chk_log("t1", e);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_no_rx", rx_got.size(), 0);
        chk("t1_err", err, 1'b0);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_proto", viol, 0);

        // four words with RX, consumer stalls word 2 for 5 cycles
        load(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tx_words.push_back(32'h1111_0000 + 32'(i));
            rx_vals.push_back(32'(i + 1));
        end
        stall_word = 2; stall_left = 5;
        start(32'h0000_0042, 8'd4, 1'b1);
        wait_done("t2", 2000, c);
        chk("t2_rx_at_done", rx_got.size(), 4);
        tick;
        for (int i = 0; i < 4 && i < rx_got.size(); i++)
            chk($sformatf("t2_rx%0d", i), rx_got[i], 32'(i + 1));
        wd.delete();
        foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 8'h08) wd.push_back(log_q[i].wdata);
        chk("t2_nwd", wd.size(), 4);
        for (int i = 0; i < 4 && i < wd.size(); i++)
            chk($sformatf("t2_wd%0d", i), wd[i], 32'h1111_0000 + 32'(i));
        chk("t2_nacc", log_q.size(), 16);
        chk("t2_stall", stall_seen, 5);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_proto", viol, 0);

        // zero words: done one cycle after start, no bus access
        load(1, 0, 0);
        start(32'h0000_0001, 8'd0, 1'b0);
        wait_done("t3", 20, c);
        chk("t3_lat", c, 0);
        tick;
        chk("t3_busy_cyc", busy_cyc, 1);
        chk("t3_cs_cyc", cs_cyc, 0);
        chk("t3_done_cnt", done_cnt, 1);

        // op_req never clears: abort after 3 polls, rest of TX left upstream
        load(0, 0, 0);
        tx_words.push_back(32'hC0DE_0001);
        tx_words.push_back(32'hC0DE_0002);
        start(32'h0000_0005, 8'd2, 1'b0);
        wait_done("t4", 500, c);
        chk("t4_err_fin", err, 1'b1);
        tick;
        chk("t4_busy", busy, 1'b0);
        chk("t4_err_sticky", err, 1'b1);
        e.delete();
        e.push_back(acc(1'b1, 8'h08, 32'hC0DE_0001));
        e.push_back(acc(1'b1, 8'h00, 32'h8000_0005));
        for (int i = 0; i < 3; i++) e.push_back(acc(1'b0, 8'h00, 32'h0));
        chk_log("t4", e);
        chk("t4_tx_cons", tx_cons.size(), 1);
        chk("t4_tx_left", {tx_valid, tx_data}, {1'b1, 32'hC0DE_0002});
        chk("t4_done_cnt", done_cnt, 1);
        load(1, 0, 0);
        start(32'h0, 8'd0, 1'b0);
        chk("t4_err_clr", err, 1'b0);
        tick;

        // random ack latency and TX gaps
        load(2, -1, 3);
        for (int i = 0; i < 6; i++) begin
            tx_words.push_back(32'h1000_0000 + 32'(i) * 32'h0101);
            rx_vals.push_back(32'hBEEF_0000 + 32'(i));
        end
        start(32'h0000_0100, 8'd6, 1'b1);
        wait_done("t5", 5000, c);
        tick;
        chk("t5_ncons", tx_cons.size(), 6);
        for (int i = 0; i < 6 && i < tx_cons.size(); i++)
            chk($sformatf("t5_cons%0d", i), tx_cons[i], 32'h1000_0000 + 32'(i) * 32'h0101);
        wd.delete();
        foreach (log_q[i]) if (log_q[i].wr && log_q[i].addr == 8'h08) wd.push_back(log_q[i].wdata);
        chk("t5_nwd", wd.size(), 6);
        for (int i = 0; i < 6 && i < wd.size(); i++)
            chk($sformatf("t5_wd%0d", i), wd[i], 32'h1000_0000 + 32'(i) * 32'h0101);
        chk("t5_nrx", rx_got.size(), 6);
        for (int i = 0; i < 6 && i < rx_got.size(); i++)
            chk($sformatf("t5_rx%0d", i), rx_got[i], 32'hBEEF_0000 + 32'(i));
        chk("t5_nacc", log_q.size(), 30);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_proto", viol, 0);

        // async reset while a poll read is on the bus
        load(0, 3, 0);
        tx_words.push_back(32'h5A5A_0006);
        start(32'h0000_0007, 8'd1, 1'b0);
        k = 0;
        while (!(m_reg.cs && !m_reg.wr) && k < 300) begin
            tick;
            k++;
        end
        chk("t6_in_pol", m_reg.cs & ~m_reg.wr, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_cs_async", m_reg.cs, 1'b0);
        chk("t6_busy_async", busy, 1'b0);
        tick; tick;
        reset_n = 1'b1;
        tick;
        load(1, 0, 0);
        tx_words.push_back(32'h0F0F_F0F0);
        start(32'h0000_0009, 8'd1, 1'b0);
        wait_done("t6", 500, c);
        tick;
        e.delete();
        e.push_back(acc(1'b1, 8'h08, 32'h0F0F_F0F0));
        e.push_back(acc(1'b1, 8'h00, 32'h8000_0009));
        e.push_back(acc(1'b0, 8'h00, 32'h0));
        chk_log("t6", e);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_err", err, 1'b0);
        chk("t6_proto", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
